// File: rtl/mips_pkg.sv
// mips_pkg -- shared constants and helpers for the MIPS front end.
//   XLEN / INSTR_W / JIDX_W : address, instruction and J-type index widths
//   RESET_PC_DEFAULT        : default PC loaded on reset
//   NOP_WORD_DEFAULT        : default instruction word used as a bubble
//   pc_sel_e                : next-PC source chosen by pc_reg
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned JIDX_W  = 26;

  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_BRANCH = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_e;

  // Every address loaded into the PC is forced word-aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // J-type target: region bits come from the sequential address, not the PC.
  function automatic logic [XLEN-1:0] jump_addr(input logic [XLEN-1:0]   pc_plus4,
                                                input logic [JIDX_W-1:0] index);
    return {pc_plus4[XLEN-1:XLEN-4], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg -- program counter with next-PC priority select.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold the PC (lowest-priority override)
//   branch_taken      : load branch_target
//   branch_target     : resolved branch address
//   jump              : load the J-type address (beats branch_taken)
//   jump_index        : J-type instr_index field
//   pc                : current PC (registered, drives the fetch address)
//   pc_plus4          : pc + 4, wrapping at 2^32
//   redirect          : jump or branch_taken is steering the next PC
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              redirect
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  pc_sel_e         pc_sel;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    redirect = jump | branch_taken;

    if (jump)              pc_sel = PC_JUMP;
    else if (branch_taken) pc_sel = PC_BRANCH;
    else if (stall)        pc_sel = PC_HOLD;
    else                   pc_sel = PC_SEQ;

    pc_d = pc_plus4;
    unique case (pc_sel)
      PC_JUMP:   pc_d = jump_addr(pc_plus4, jump_index);
      PC_BRANCH: pc_d = word_align(branch_target);
      PC_HOLD:   pc_d = pc_q;
      PC_SEQ:    pc_d = pc_plus4;
      default:   pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= word_align(RESET_PC);
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold PC and IF/ID
//   flush             : squash IF/ID to a bubble
//   branch_taken      : redirect to branch_target
//   branch_target     : resolved branch address
//   jump              : redirect to the J-type address
//   jump_index        : J-type instr_index field
//   imem_pc           : fetch address (straight from the PC flop)
//   imem_instruction  : memory word for imem_pc, same cycle
//   ifid_instruction  : registered instruction for decode
//   ifid_pc_plus4     : registered PC+4 of that instruction
//   ifid_valid        : IF/ID holds a real instruction
//   fetch_count       : instructions accepted into IF/ID
module if_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic               jump,
  input  logic [JIDX_W-1:0]  jump_index,
  output logic [XLEN-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] ifid_instruction,
  output logic [XLEN-1:0]    ifid_pc_plus4,
  output logic               ifid_valid,
  output logic [31:0]        fetch_count
);

  logic [XLEN-1:0]    pc_plus4;
  logic               redirect;

  logic [INSTR_W-1:0] ifid_instruction_q, ifid_instruction_d;
  logic [XLEN-1:0]    ifid_pc_plus4_q,    ifid_pc_plus4_d;
  logic               ifid_valid_q,       ifid_valid_d;
  logic [31:0]        fetch_count_q,      fetch_count_d;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .pc            (imem_pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect)
  );

  // The word being fetched during a redirect is on the wrong path, so it is
  // replaced by a bubble even under stall; that bubble is the one-cycle cost.
  // Bubbles still record pc_plus4 so the IF/ID address stays traceable.
  always_comb begin
    ifid_instruction_d = ifid_instruction_q;
    ifid_pc_plus4_d    = ifid_pc_plus4_q;
    ifid_valid_d       = ifid_valid_q;
    fetch_count_d      = fetch_count_q;

    if (redirect || flush) begin
      ifid_instruction_d = NOP_WORD;
      ifid_pc_plus4_d    = pc_plus4;
      ifid_valid_d       = 1'b0;
    end else if (!stall) begin
      ifid_instruction_d = imem_instruction;
      ifid_pc_plus4_d    = pc_plus4;
      ifid_valid_d       = 1'b1;
      fetch_count_d      = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instruction_q <= NOP_WORD;
      ifid_pc_plus4_q    <= '0;
      ifid_valid_q       <= 1'b0;
      fetch_count_q      <= '0;
    end else begin
      ifid_instruction_q <= ifid_instruction_d;
      ifid_pc_plus4_q    <= ifid_pc_plus4_d;
      ifid_valid_q       <= ifid_valid_d;
      fetch_count_q      <= fetch_count_d;
    end
  end

  assign ifid_instruction = ifid_instruction_q;
  assign ifid_pc_plus4    = ifid_pc_plus4_q;
  assign ifid_valid       = ifid_valid_q;
  assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_index       (jump_index),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid),
    .fetch_count      (fetch_count)
  );

  // Instruction memory: word at address A is {A[15:0], 16'hBEEF}.
  assign imem_instruction = {imem_pc[15:0], 16'hBEEF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush, br;
    logic [31:0] bt;
    logic        jmp;
    logic [25:0] ji;
    logic [31:0] e_pc, e_ins, e_p4;
    logic        e_v, chk_p4;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e_pc, e_ins, e_p4;
    logic        e_v, chk_p4;
    logic [31:0] e_cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic s, input logic f, input logic b,
                     input logic [31:0] bt, input logic j, input logic [25:0] ji,
                     input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] p4,
                     input logic v, input logic cp4, input logic [31:0] cnt);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.br = b; t.bt = bt; t.jmp = j; t.ji = ji;
    t.e_pc = pc; t.e_ins = ins; t.e_p4 = p4; t.e_v = v; t.chk_p4 = cp4; t.e_cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic check(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Monitor: after every rising edge, pop one expectation and compare.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.idx, "imem_pc", imem_pc, e.e_pc);
      check(e.idx, "ifid_instruction", ifid_instruction, e.e_ins);
      check(e.idx, "ifid_valid", {31'd0, ifid_valid}, {31'd0, e.e_v});
      check(e.idx, "fetch_count", fetch_count, e.e_cnt);
      if (e.chk_p4) check(e.idx, "ifid_pc_plus4", ifid_pc_plus4, e.e_p4);
    end
  end

  initial begin
    //   rst s f br bt            j ji         pc            ins           p4            v cp4 cnt
    add(1, 0,0,0, 32'h0,        0,26'h0,      32'h0,        32'h0,        32'h0,        0,1, 0);
    add(1, 0,0,0, 32'h0,        0,26'h0,      32'h0,        32'h0,        32'h0,        0,1, 0);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h4,        32'h0000BEEF, 32'h4,        1,1, 1);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h8,        32'h0004BEEF, 32'h8,        1,1, 2);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'hC,        32'h0008BEEF, 32'hC,        1,1, 3);
    add(1, 0,0,0, 32'h0,        0,26'h0,      32'h0,        32'h0,        32'h0,        0,1, 0);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h4,        32'h0000BEEF, 32'h4,        1,1, 1);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h8,        32'h0004BEEF, 32'h8,        1,1, 2);
    add(0, 1,0,0, 32'h0,        0,26'h0,      32'h8,        32'h0004BEEF, 32'h8,        1,1, 2);
    add(0, 1,0,0, 32'h0,        0,26'h0,      32'h8,        32'h0004BEEF, 32'h8,        1,1, 2);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'hC,        32'h0008BEEF, 32'hC,        1,1, 3);
    add(0, 1,0,1, 32'h40,       0,26'h0,      32'h40,       32'h0,        32'h0,        0,0, 3);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h44,       32'h0040BEEF, 32'h44,       1,1, 4);
    add(0, 0,0,1, 32'h1000_0010,0,26'h0,      32'h1000_0010,32'h0,        32'h0,        0,0, 4);
    add(0, 0,0,1, 32'h80,       1,26'h10,     32'h1000_0040,32'h0,        32'h0,        0,0, 4);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h1000_0044,32'h0040BEEF, 32'h1000_0044,1,1, 5);
    add(0, 0,0,1, 32'h14,       0,26'h0,      32'h14,       32'h0,        32'h0,        0,0, 5);
    add(0, 0,1,0, 32'h0,        0,26'h0,      32'h18,       32'h0,        32'h0,        0,0, 5);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h1C,       32'h0018BEEF, 32'h1C,       1,1, 6);
    add(0, 0,0,1, 32'h103,      0,26'h0,      32'h100,      32'h0,        32'h0,        0,0, 6);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h104,      32'h0100BEEF, 32'h104,      1,1, 7);
    add(0, 1,1,0, 32'h0,        0,26'h0,      32'h104,      32'h0,        32'h0,        0,0, 7);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h108,      32'h0104BEEF, 32'h108,      1,1, 8);
    add(0, 0,0,1, 32'hFFFF_FFFC,0,26'h0,      32'hFFFF_FFFC,32'h0,        32'h0,        0,0, 8);
    add(0, 1,0,0, 32'h0,        0,26'h0,      32'hFFFF_FFFC,32'h0,        32'h0,        0,0, 8);
    add(1, 1,0,0, 32'h0,        0,26'h0,      32'h0,        32'h0,        32'h0,        0,1, 0);
    add(0, 0,0,1, 32'hFFFF_FFFC,0,26'h0,      32'hFFFF_FFFC,32'h0,        32'h0,        0,0, 0);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h0,        32'hFFFCBEEF, 32'h0,        1,1, 1);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h4,        32'h0000BEEF, 32'h4,        1,1, 2);
    add(0, 1,0,0, 32'h0,        1,26'h3FFFFFF,32'h0FFF_FFFC,32'h0,        32'h0,        0,0, 2);
    add(0, 0,0,0, 32'h0,        0,26'h0,      32'h1000_0000,32'hFFFCBEEF, 32'h1000_0000,1,1, 3);

    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = '0; jump = 1'b0; jump_index = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clk);
      rst           = vecs[i].rst;
      stall         = vecs[i].stall;
      flush         = vecs[i].flush;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].bt;
      jump          = vecs[i].jmp;
      jump_index    = vecs[i].ji;
      e.idx = i; e.e_pc = vecs[i].e_pc; e.e_ins = vecs[i].e_ins; e.e_p4 = vecs[i].e_p4;
      e.e_v = vecs[i].e_v; e.chk_p4 = vecs[i].chk_p4; e.e_cnt = vecs[i].e_cnt;
      sb.push_back(e);
    end

    @(negedge clk);
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at %0t, required finish before 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
